stream_mux_n: RTL and testbench

- Parametrised N-input, W-bit multiplexer with a registered output and valid/ready handshakes on every port.
- Successor to the combinational 3:1 2-bit mux. Adds arbitrary width and channel count, a selectable round-robin mode, backpressure and one output buffer stage.
- Sits between several producer streams and one consumer. A typical use is merging request streams onto a single bus.

---
 rtl/rr_arbiter_n.sv | 43 ++++
 rtl/stream_mux_n.sv | 109 ++++++++++
 tb/tb_stream_mux_n.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_n.sv
// Combinational N-way arbiter: grants the first requester found searching
// upward from ptr, wrapping from N-1 back to 0.
module rr_arbiter_n #(
  parameter int N = 3,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] gidx
);

  logic found_s;
  int   idx_s;

  // Priority search starting at ptr; indices are wrapped with a subtraction so non-power-of-2 N is exact
  always_comb begin
    found_s = 1'b0;
    gidx    = '0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = int'(ptr) + k;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        gidx    = SW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    if (en && found_s) begin
      grant = {{(N-1){1'b0}}, 1'b1} << gidx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-input, W-bit stream multiplexer with select or round-robin arbitration,
// valid/ready handshakes and a single registered output stage.
module stream_mux_n #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*W-1:0]         in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic                   rr_mode,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int SW = $clog2(N);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic          load_en_s;
  logic          arb_en_s;
  logic [SW-1:0] sel_eff_s;
  logic [N-1:0]  arb_req_s;
  logic [N-1:0]  grant_s;
  logic [SW-1:0] gidx_s;
  logic          xfer_s;

  // Clamp out-of-range selects to the last channel; in select mode only that channel may request
  always_comb begin
    if (int'(sel) >= N) begin
      sel_eff_s = SW'(N - 1);
    end else begin
      sel_eff_s = sel;
    end
    if (rr_mode) begin
      arb_req_s = in_valid;
    end else begin
      arb_req_s = in_valid & ({{(N-1){1'b0}}, 1'b1} << sel_eff_s);
    end
  end

  assign load_en_s = !out_valid_q || out_ready;
  assign arb_en_s  = load_en_s && !rst;

  rr_arbiter_n #(.N(N)) u_arb (
    .req   (arb_req_s),
    .ptr   (ptr_q),
    .en    (arb_en_s),
    .grant (grant_s),
    .gidx  (gidx_s)
  );

  // A grant is only issued to a valid requester, so any grant bit is a transfer
  assign xfer_s   = |grant_s;
  assign in_ready = grant_s;

  // Next-state for the output stage and the round-robin pointer
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_data_d  = in_data[int'(gidx_s)*W +: W];
      out_ch_d    = gidx_s;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s && rr_mode) begin
      if (gidx_s == SW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx_s + SW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n (N=3, W=2): directed scenarios followed by
// randomized traffic, checked against a behavioural arbitration model.
module tb_stream_mux_n;

  localparam int N = 3;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   in_data;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [1:0]   sel;
  logic         rr_mode;
  logic [1:0]   out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  typedef struct {
    logic [1:0] d;
    logic [1:0] ch;
  } exp_t;

  exp_t sb_q[$];
  int   m_ptr;
  bit   m_occ;
  int   n_chk;
  int   n_pass;

  stream_mux_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: channel chosen from the rules, -1 when nobody wins
  function automatic int model_grant(input logic [2:0] v, input logic [1:0] s, input logic rr);
    int e;
    if (!rr) begin
      e = (int'(s) >= N) ? N - 1 : int'(s);
      return v[e] ? e : -1;
    end
    for (int k = 0; k < N; k++) begin
      e = (m_ptr + k) % N;
      if (v[e]) return e;
    end
    return -1;
  endfunction

  // One cycle of stimulus: drive, check in_ready at negedge, update the model at the edge
  task automatic step(input logic [2:0] v, input logic [5:0] d, input logic [1:0] s,
                      input logic rr, input logic ordy);
    int         g;
    logic [2:0] exp_rdy;
    exp_t       e;
    in_valid  = v;
    in_data   = d;
    sel       = s;
    rr_mode   = rr;
    out_ready = ordy;
    @(negedge clk);
    g = model_grant(v, s, rr);
    exp_rdy = ((!m_occ || ordy) && g >= 0) ? 3'(1 << g) : 3'b000;
    chk("in_ready", {29'd0, in_ready}, {29'd0, exp_rdy});
    @(posedge clk);
    if (exp_rdy != 3'b000) begin
      e.d  = d[g*2 +: 2];
      e.ch = 2'(g);
      sb_q.push_back(e);
      if (rr) m_ptr = (g + 1) % N;
      m_occ = 1'b1;
    end else if (ordy) begin
      m_occ = 1'b0;
    end
    #1;
  endtask

  // Monitor: compare the presented word against the scoreboard head, pop on handshake
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() != 0)});
      if (out_valid && sb_q.size() > 0) begin
        chk("out_data", {30'd0, out_data}, {30'd0, sb_q[0].d});
        chk("out_ch", {30'd0, out_ch}, {30'd0, sb_q[0].ch});
        if (out_ready) sb_q.delete(0);
      end
    end
  end

  localparam logic [5:0] D = {2'b11, 2'b10, 2'b01};

  initial begin
    n_chk = 0; n_pass = 0; m_ptr = 0; m_occ = 1'b0;
    rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; rr_mode = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {30'd0, out_data}, 32'd0);
    chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Select mode, including the out-of-range select
    step(3'b111, D, 2'd1, 1'b0, 1'b1);
    step(3'b111, D, 2'd3, 1'b0, 1'b1);
    // Backpressure holds the registered word
    repeat (4) step(3'b111, D, 2'd0, 1'b0, 1'b0);
    step(3'b111, D, 2'd0, 1'b0, 1'b1);
    // Round-robin, all valid then channels 0 and 2 only
    repeat (6) step(3'b111, D, 2'd0, 1'b1, 1'b1);
    repeat (4) step(3'b101, D, 2'd0, 1'b1, 1'b1);
    // Idle bubble then a single word on channel 1
    repeat (2) step(3'b000, D, 2'd0, 1'b1, 1'b1);
    step(3'b010, D, 2'd0, 1'b1, 1'b1);

    // Asynchronous reset between clock edges with a word held in the output
    #2 rst = 1'b1; in_valid = 3'b111; out_ready = 1'b1; rr_mode = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {30'd0, out_data}, 32'd0);
    chk("arst_out_ch", {30'd0, out_ch}, 32'd0);
    chk("arst_in_ready", {29'd0, in_ready}, 32'd0);
    sb_q.delete();
    m_occ = 1'b0;
    m_ptr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(3'b111, D, 2'd0, 1'b1, 1'b1);

    // Randomized traffic with mode switches and intermittent backpressure
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 6'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    repeat (3) step(3'b000, 6'd0, 2'd0, 1'b0, 1'b1);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
